// File: rtl/frame_buffer_2x.sv
// Double-buffered 16x16 red/green pixel store feeding the LED display driver.
// Game logic draws into the back buffer; swaps wait for the next display frame boundary.
module frame_buffer_2x #(
  parameter bit AUTO_CLEAR           = 1'b1,
  parameter int CLEAR_ROWS_PER_CYCLE = 1
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              WrValid_i,
  output logic              WrReady_o,
  input  logic [3:0]        WrX_i,
  input  logic [3:0]        WrY_i,
  input  logic [1:0]        WrColor_i,
  input  logic              ClearReq_i,
  input  logic              SwapReq_i,
  input  logic              FrameTick_i,
  output logic              SwapPending_o,
  output logic              SwapDone_o,
  output logic              Busy_o,
  output logic [15:0][15:0] RedPixels_o,
  output logic [15:0][15:0] GrnPixels_o
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP_WAIT
  } state_e;

  localparam logic [3:0] ROW_STEP = 4'(CLEAR_ROWS_PER_CYCLE);
  localparam logic [3:0] LAST_ROW = 4'(16 - CLEAR_ROWS_PER_CYCLE);

  state_e                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic                   swapDone_q, swapDone_d;
  logic                   frontSel_q, frontSel_d;
  logic [3:0]             rowCnt_q, rowCnt_d;
  logic [1:0][15:0][15:0] red_q, red_d;
  logic [1:0][15:0][15:0] grn_q, grn_d;
  logic                   back;

  assign back = ~frontSel_q;

  always_ff @(posedge CLK_i) begin
    if (!RST_i) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      swapDone_q <= 1'b0;
      frontSel_q <= 1'b0;
      rowCnt_q   <= '0;
      red_q      <= '0;
      grn_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      swapDone_q <= swapDone_d;
      frontSel_q <= frontSel_d;
      rowCnt_q   <= rowCnt_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | SwapReq_i;
    swapDone_d = 1'b0;
    frontSel_d = frontSel_q;
    rowCnt_d   = rowCnt_q;
    red_d      = red_q;
    grn_d      = grn_q;
    WrReady_o  = 1'b0;

    case (state_q)
      IDLE: begin
        WrReady_o = RST_i;
        if (WrValid_i) begin
          red_d[back][WrY_i][WrX_i] = WrColor_i[0];
          grn_d[back][WrY_i][WrX_i] = WrColor_i[1];
        end
        if (ClearReq_i) begin
          state_d = CLEAR;
        end else if (pending_d) begin
          state_d = SWAP_WAIT;
        end
      end

      CLEAR: begin
        for (int k = 0; k < CLEAR_ROWS_PER_CYCLE; k++) begin
          red_d[back][rowCnt_q + 4'(k)] = '0;
          grn_d[back][rowCnt_q + 4'(k)] = '0;
        end
        rowCnt_d = rowCnt_q + ROW_STEP;
        if (rowCnt_q == LAST_ROW) begin
          state_d = pending_d ? SWAP_WAIT : IDLE;
        end
      end

      SWAP_WAIT: begin
        // A request arriving on the swap cycle itself starts a fresh pending swap.
        if (FrameTick_i) begin
          frontSel_d = ~frontSel_q;
          pending_d  = SwapReq_i;
          swapDone_d = 1'b1;
          state_d    = AUTO_CLEAR ? CLEAR : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign SwapPending_o = pending_q;
  assign SwapDone_o    = swapDone_q;
  assign Busy_o        = (state_q != IDLE);
  assign RedPixels_o   = red_q[frontSel_q];
  assign GrnPixels_o   = grn_q[frontSel_q];

endmodule

// File: tb/tb_frame_buffer_2x.sv
// Directed self-checking bench for frame_buffer_2x with default parameters.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_frame_buffer_2x;

  logic              CLK_i = 1'b0;
  logic              RST_i;
  logic              WrValid_i;
  logic              WrReady_o;
  logic [3:0]        WrX_i;
  logic [3:0]        WrY_i;
  logic [1:0]        WrColor_i;
  logic              ClearReq_i;
  logic              SwapReq_i;
  logic              FrameTick_i;
  logic              SwapPending_o;
  logic              SwapDone_o;
  logic              Busy_o;
  logic [15:0][15:0] RedPixels_o;
  logic [15:0][15:0] GrnPixels_o;

  int testsRun    = 0;
  int testsFailed = 0;
  int n;
  int doneCnt;

  frame_buffer_2x dut (
    .CLK_i        (CLK_i),
    .RST_i        (RST_i),
    .WrValid_i    (WrValid_i),
    .WrReady_o    (WrReady_o),
    .WrX_i        (WrX_i),
    .WrY_i        (WrY_i),
    .WrColor_i    (WrColor_i),
    .ClearReq_i   (ClearReq_i),
    .SwapReq_i    (SwapReq_i),
    .FrameTick_i  (FrameTick_i),
    .SwapPending_o(SwapPending_o),
    .SwapDone_o   (SwapDone_o),
    .Busy_o       (Busy_o),
    .RedPixels_o  (RedPixels_o),
    .GrnPixels_o  (GrnPixels_o)
  );

  always #5 CLK_i = ~CLK_i;

  function automatic logic [255:0] pix(input int y, input int x);
    return 256'(1) << (y * 16 + x);
  endfunction

  task automatic step();
    @(posedge CLK_i);
    #1;
  endtask

  task automatic applyStimulus(input logic wv, input logic [3:0] x, input logic [3:0] y,
                               input logic [1:0] c, input logic clr, input logic swp,
                               input logic tick);
    WrValid_i   = wv;
    WrX_i       = x;
    WrY_i       = y;
    WrColor_i   = c;
    ClearReq_i  = clr;
    SwapReq_i   = swp;
    FrameTick_i = tick;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checkOutput(tag, 256'(obs), 256'(exp));
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checkOutput(tag, 256'(obs), 256'(exp));
  endtask

  // Steps until Busy drops, counting busy samples; the bound keeps a stuck DUT from hanging.
  task automatic waitIdle(output int cnt);
    cnt = 0;
    while (Busy_o && cnt < 64) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    RST_i = 1'b0;
    idle();

    // Reset
    step();
    step();
    checkFlag("wrready_in_reset", WrReady_o, 1'b0);
    RST_i = 1'b1;
    step();
    checkOutput("reset_red", RedPixels_o, '0);
    checkOutput("reset_grn", GrnPixels_o, '0);
    checkFlag("reset_wrready", WrReady_o, 1'b1);
    checkFlag("reset_busy", Busy_o, 1'b0);
    checkFlag("reset_pending", SwapPending_o, 1'b0);
    checkFlag("reset_swapdone", SwapDone_o, 1'b0);

    // Write then swap
    applyStimulus(1'b1, 4'd3, 4'd5, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    checkOutput("write_hidden_red", RedPixels_o, '0);
    checkOutput("write_hidden_grn", GrnPixels_o, '0);
    SwapReq_i = 1'b1;
    step();
    idle();
    checkFlag("swapreq_pending", SwapPending_o, 1'b1);
    checkFlag("swapwait_busy", Busy_o, 1'b1);
    checkFlag("swapwait_wrready", WrReady_o, 1'b0);
    repeat (10) step();
    checkFlag("swapwait_no_done", SwapDone_o, 1'b0);
    checkOutput("swapwait_red", RedPixels_o, '0);
    FrameTick_i = 1'b1;
    step();
    idle();
    checkFlag("swap1_done", SwapDone_o, 1'b1);
    checkFlag("swap1_pending_clr", SwapPending_o, 1'b0);
    checkOutput("swap1_red", RedPixels_o, pix(5, 3));
    checkOutput("swap1_grn", GrnPixels_o, pix(5, 3));
    n = 0;
    doneCnt = 0;
    while (Busy_o && n < 64) begin
      n++;
      if (SwapDone_o) doneCnt++;
      step();
    end
    checkCount("autoclear_len", n, 16);
    checkCount("swapdone_pulses", doneCnt, 1);
    checkFlag("autoclear_wrready", WrReady_o, 1'b1);

    // Stall: write held while swap and auto-clear run
    SwapReq_i = 1'b1;
    step();
    applyStimulus(1'b1, 4'd0, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    checkFlag("stall_wrready", WrReady_o, 1'b0);
    FrameTick_i = 1'b1;
    step();
    FrameTick_i = 1'b0;
    checkFlag("swap2_done", SwapDone_o, 1'b1);
    checkOutput("swap2_red", RedPixels_o, '0);
    n = 0;
    while (!WrReady_o && n < 64) begin
      n++;
      step();
    end
    checkCount("stall_len", n, 16);
    step();
    idle();
    checkOutput("stall_write_hidden", RedPixels_o, '0);
    SwapReq_i = 1'b1;
    step();
    idle();
    FrameTick_i = 1'b1;
    step();
    idle();
    checkOutput("swap3_red", RedPixels_o, pix(0, 0));
    checkOutput("swap3_grn", GrnPixels_o, '0);
    waitIdle(n);
    checkCount("swap3_clear_len", n, 16);

    // Simultaneous ClearReq and SwapReq with a pixel in the back buffer
    applyStimulus(1'b1, 4'd7, 4'd9, 2'b10, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    checkFlag("simul_busy", Busy_o, 1'b1);
    checkFlag("simul_pending", SwapPending_o, 1'b1);
    repeat (16) step();
    checkFlag("simul_wait_busy", Busy_o, 1'b1);
    checkFlag("simul_wait_pending", SwapPending_o, 1'b1);
    checkFlag("simul_wait_no_done", SwapDone_o, 1'b0);
    checkOutput("simul_front_kept", RedPixels_o, pix(0, 0));
    FrameTick_i = 1'b1;
    step();
    idle();
    checkFlag("simul_done", SwapDone_o, 1'b1);
    checkOutput("simul_red", RedPixels_o, '0);
    checkOutput("simul_grn", GrnPixels_o, '0);
    waitIdle(n);
    checkCount("simul_clear_len", n, 16);

    // Reset mid-clear with a swap pending
    applyStimulus(1'b1, 4'd2, 4'd2, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    FrameTick_i = 1'b1;
    step();
    idle();
    checkOutput("swap4_red", RedPixels_o, pix(2, 2));
    SwapReq_i = 1'b1;
    step();
    idle();
    repeat (5) step();
    RST_i = 1'b0;
    step();
    checkOutput("midrst_red", RedPixels_o, '0);
    checkOutput("midrst_grn", GrnPixels_o, '0);
    checkFlag("midrst_pending", SwapPending_o, 1'b0);
    checkFlag("midrst_busy", Busy_o, 1'b0);
    checkFlag("midrst_wrready", WrReady_o, 1'b0);
    RST_i = 1'b1;
    step();
    checkFlag("postrst_wrready", WrReady_o, 1'b1);
    repeat (3) step();
    FrameTick_i = 1'b1;
    step();
    idle();
    checkFlag("postrst_no_swap", SwapDone_o, 1'b0);
    checkFlag("postrst_busy", Busy_o, 1'b0);

    // Overwrite, corner pixels, and FrameTick ignored outside SWAP_WAIT
    applyStimulus(1'b1, 4'd15, 4'd15, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 4'd15, 4'd15, 2'b10, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 4'd0, 4'd15, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    FrameTick_i = 1'b1;
    step();
    idle();
    checkOutput("swap5_red", RedPixels_o, pix(15, 0));
    checkOutput("swap5_grn", GrnPixels_o, pix(15, 15));
    repeat (3) step();
    FrameTick_i = 1'b1;
    step();
    idle();
    checkFlag("tick_in_clear_done", SwapDone_o, 1'b0);
    checkFlag("tick_in_clear_busy", Busy_o, 1'b1);
    checkOutput("tick_in_clear_red", RedPixels_o, pix(15, 0));
    waitIdle(n);
    checkFlag("tick_clear_finished", Busy_o, 1'b0);
    FrameTick_i = 1'b1;
    step();
    idle();
    checkFlag("tick_in_idle_done", SwapDone_o, 1'b0);
    checkFlag("tick_in_idle_busy", Busy_o, 1'b0);
    checkOutput("tick_in_idle_red", RedPixels_o, pix(15, 0));
    checkOutput("tick_in_idle_grn", GrnPixels_o, pix(15, 15));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
